pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Decides each cycle whether the pipeline runs, stalls, flushes or freezes:
  - load-use stall: one bubble into ID/EX, PC and IF/ID held;
  - taken-branch flush of IF/ID;
  - full-pipeline freeze while the data memory has not acknowledged;
  - startup hold until the start pulse.
- Works alongside the forwarding unit; covers only the hazards forwarding cannot resolve.

Parameters:
- MISS_TIMEOUT, 64: maximum consecutive freeze cycles on one memory access before a fatal error.
- CNT_W, 32: width of the performance counters (optional feature).

Ports:
- clk_i  input  1  core clock, rising edge
- rst_i  input  1  asynchronous active-low reset
- start_i  input  1  sampled in IDLE; 1 starts the pipeline
- IDEX_memread  input  1  instruction in EX is a load
- IDEX_rt  input  5  destination of the load in EX
- IFID_rs  input  5  rs of the instruction in ID
- IFID_rt  input  5  rt of the instruction in ID
- branch_taken_i  input  1  branch in ID resolved taken
- mem_req_i  input  1  MEM stage issues a data-memory read or write this cycle
- mem_ack_i  input  1  data memory completes the access this cycle
- PC_write  output  1  1 = PC may update
- IFID_write  output  1  1 = IF/ID may update
- IDEX_bubble  output  1  1 = load zeroed control (NOP) into ID/EX
- IFID_flush  output  1  1 = load NOP into IF/ID
- pipe_freeze  output  1  1 = hold ID/EX, EX/MEM, MEM/WB
- err_o  output  1  sticky memory-timeout error
- stall_cnt_o, flush_cnt_o, miss_cnt_o  output  CNT_W each  performance counters

Behaviour:
- States: IDLE, RUN, MISS, HALT. State and miss counter are registered; all other outputs are combinational from state and inputs.
- Reset (rst_i=0, asynchronous): state=IDLE, miss counter=0, err_o=0.
  - IDLE outputs: PC_write=0, IFID_write=0, IDEX_bubble=1, IFID_flush=0, pipe_freeze=0.
- IDLE: start_i=1 at a clock edge -> RUN. Outputs keep IDLE values during the start_i cycle.
- RUN: freeze condition F = mem_req_i & ~mem_ack_i.
  - If F: pipe_freeze=1, PC_write=0, IFID_write=0, IDEX_bubble=0, IFID_flush=0; next state MISS, miss counter=1.
  - Else if load-use L = IDEX_memread & (IDEX_rt!=0) & (IDEX_rt==IFID_rs | IDEX_rt==IFID_rt): PC_write=0, IFID_write=0, IDEX_bubble=1, IFID_flush=0. Lasts exactly one cycle because the bubble clears IDEX_memread.
  - Else if branch_taken_i: PC_write=1, IFID_write=1, IFID_flush=1, IDEX_bubble=0.
  - Else: PC_write=1, IFID_write=1, all others 0.
  - Priority: freeze > load-use > flush. A load-use on a branch suppresses the flush; the branch re-resolves the next cycle.
- MISS:
  - pipe_freeze=~mem_ack_i, PC_write=IFID_write=mem_ack_i; other outputs 0.
  - mem_ack_i=1 -> RUN, counter cleared. The ack cycle already advances the pipeline; L and flush are not evaluated in that cycle.
  - Else the counter increments; when it reaches MISS_TIMEOUT -> HALT, err_o=1.
  - Counter is sized ceil(log2(MISS_TIMEOUT+1)) bits and never wraps.
- HALT: terminal until reset.
  - Outputs: pipe_freeze=1, PC_write=0, IFID_write=0, IDEX_bubble=0, IFID_flush=0, err_o=1.
- Reset mid-operation from any state -> IDLE immediately; no pending stall or flush survives.
- A zero-cycle access (mem_req_i & mem_ack_i in the same cycle) never freezes.

Optional Feature:
- HAZ_PERF_CNT_EN defined:
  - stall_cnt_o counts RUN cycles with L active and F inactive.
  - flush_cnt_o counts cycles with IFID_flush=1.
  - miss_cnt_o counts cycles with pipe_freeze=1 in RUN or MISS.
  - All counters saturate at all-ones, reset to 0 and do not count in IDLE or HALT.
- Not defined: the counters are not built; the three ports remain and are driven constant 0.

Test Plan:
- Reset, hold start_i=0 for 5 cycles -> PC_write=0 and IDEX_bubble=1 throughout. Pulse start_i -> PC_write=1 from the next cycle.
- RUN with IDEX_memread=1, IDEX_rt=8, IFID_rt=8 -> one cycle of PC_write=0, IFID_write=0, IDEX_bubble=1. Repeat with IDEX_rt=0 -> no stall.
- Load-use and branch_taken_i=1 in the same cycle -> IFID_flush=0 and a stall. Next cycle branch_taken_i=1 with no hazard -> IFID_flush=1.
- mem_req_i=1 with mem_ack_i arriving after 3 cycles -> pipe_freeze=1 for 3 cycles and 0 in the ack cycle, PC_write=1 in the ack cycle; miss_cnt_o=3 with HAZ_PERF_CNT_EN.
- mem_req_i=1 with ack never asserted, MISS_TIMEOUT=4 -> HALT after 4 freeze cycles, err_o=1 sticky. rst_i pulse low mid-HALT -> IDLE, err_o=0.
- rst_i asserted low during MISS between clock edges -> outputs take IDLE values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall, branch flush, memory freeze, startup hold.
// Optional saturating performance counters are built when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
    parameter int MISS_TIMEOUT = 64,
    parameter int CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             IDEX_memread,
    input  logic [4:0]       IDEX_rt,
    input  logic [4:0]       IFID_rs,
    input  logic [4:0]       IFID_rt,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             PC_write,
    output logic             IFID_write,
    output logic             IDEX_bubble,
    output logic             IFID_flush,
    output logic             pipe_freeze,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] miss_cnt_o
);

    localparam int MCW = $clog2(MISS_TIMEOUT + 1);
    localparam logic [MCW-1:0] TIMEOUT = MCW'(MISS_TIMEOUT);
    localparam logic [MCW-1:0] ONE     = MCW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        MISS = 2'd2,
        HALT = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [MCW-1:0] r_miss;
    logic [MCW-1:0] w_miss_next;
    logic           w_freeze;
    logic           w_load_use;

    assign w_freeze   = mem_req_i & ~mem_ack_i;
    assign w_load_use = IDEX_memread & (IDEX_rt != 5'd0) &
                        ((IDEX_rt == IFID_rs) | (IDEX_rt == IFID_rt));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_miss  <= '0;
        end else begin
            r_state <= w_next;
            r_miss  <= w_miss_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_miss_next = r_miss;
        PC_write    = 1'b0;
        IFID_write  = 1'b0;
        IDEX_bubble = 1'b0;
        IFID_flush  = 1'b0;
        pipe_freeze = 1'b0;
        unique case (r_state)
            IDLE: begin
                IDEX_bubble = 1'b1;
                if (start_i) w_next = RUN;
            end
            RUN: begin
                if (w_freeze) begin
                    pipe_freeze = 1'b1;
                    w_miss_next = ONE;
                    w_next      = (TIMEOUT <= ONE) ? HALT : MISS;
                end else if (w_load_use) begin
                    IDEX_bubble = 1'b1;
                end else begin
                    PC_write   = 1'b1;
                    IFID_write = 1'b1;
                    IFID_flush = branch_taken_i;
                end
            end
            MISS: begin
                pipe_freeze = ~mem_ack_i;
                PC_write    = mem_ack_i;
                IFID_write  = mem_ack_i;
                if (mem_ack_i) begin
                    w_next      = RUN;
                    w_miss_next = '0;
                end else if (r_miss >= TIMEOUT - ONE) begin
                    // Saturate at the limit so the counter can never wrap
                    w_next      = HALT;
                    w_miss_next = TIMEOUT;
                end else begin
                    w_miss_next = r_miss + ONE;
                end
            end
            HALT: begin
                pipe_freeze = 1'b1;
            end
            default: begin
                w_next      = IDLE;
                w_miss_next = '0;
            end
        endcase
    end

    assign err_o = (r_state == HALT);

`ifdef HAZ_PERF_CNT_EN
    logic             w_active;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_miss_cnt;

    assign w_active = (r_state == RUN) | (r_state == MISS);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_miss_cnt  <= '0;
        end else begin
            if ((r_state == RUN) && w_load_use && !w_freeze && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (IFID_flush && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            if (w_active && pipe_freeze && (r_miss_cnt != '1))
                r_miss_cnt <= r_miss_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
    assign miss_cnt_o  = r_miss_cnt;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
    assign miss_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vectors, literal checks and a per-cycle model compare.
// Counter checks follow HAZ_PERF_CNT_EN the same way the design does.
module tb_pipe_hazard_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        memread;
    logic [4:0]  ex_rt;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        branch;
    logic        mem_req;
    logic        mem_ack;
    logic        PC_write;
    logic        IFID_write;
    logic        IDEX_bubble;
    logic        IFID_flush;
    logic        pipe_freeze;
    logic        err_o;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic [31:0] miss_cnt;

    int tests = 0;
    int fails = 0;

    // model state: high-level view of the pipeline
    bit started;
    bit halted;
    int waiting;
    int m_stall;
    int m_flush;
    int m_miss;

    pipe_hazard_ctrl #(.MISS_TIMEOUT(TO), .CNT_W(32)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .IDEX_memread   (memread),
        .IDEX_rt        (ex_rt),
        .IFID_rs        (id_rs),
        .IFID_rt        (id_rt),
        .branch_taken_i (branch),
        .mem_req_i      (mem_req),
        .mem_ack_i      (mem_ack),
        .PC_write       (PC_write),
        .IFID_write     (IFID_write),
        .IDEX_bubble    (IDEX_bubble),
        .IFID_flush     (IFID_flush),
        .pipe_freeze    (pipe_freeze),
        .err_o          (err_o),
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt),
        .miss_cnt_o     (miss_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit f_now();
        return mem_req && !mem_ack;
    endfunction

    function automatic bit l_now();
        return memread && (ex_rt != 0) && (ex_rt == id_rs || ex_rt == id_rt);
    endfunction

    // {PC_write, IFID_write, IDEX_bubble, IFID_flush, pipe_freeze, err_o}
    function automatic logic [5:0] model_out();
        if (!started) return 6'b001000;
        if (halted) return 6'b000011;
        if (waiting > 0) return {mem_ack, mem_ack, 2'b00, !mem_ack, 1'b0};
        if (f_now()) return 6'b000010;
        if (l_now()) return 6'b001000;
        return {2'b11, 1'b0, branch, 2'b00};
    endfunction

    always @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            started = 0;
            halted  = 0;
            waiting = 0;
            m_stall = 0;
            m_flush = 0;
            m_miss  = 0;
        end else if (!started) begin
            started = start_i;
        end else if (!halted) begin
            logic [5:0] o;
            o = model_out();
            if (o[1]) m_miss++;
            if (o[2]) m_flush++;
            if (waiting == 0 && !f_now() && l_now()) m_stall++;
            if (waiting > 0) begin
                if (mem_ack) waiting = 0;
                else waiting++;
            end else if (f_now()) begin
                waiting = 1;
            end
            if (waiting >= TO) halted = 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [5:0] o;
        o = model_out();
        chk("m_PC_write", 32'(PC_write), 32'(o[5]));
        chk("m_IFID_write", 32'(IFID_write), 32'(o[4]));
        chk("m_IDEX_bubble", 32'(IDEX_bubble), 32'(o[3]));
        chk("m_IFID_flush", 32'(IFID_flush), 32'(o[2]));
        chk("m_pipe_freeze", 32'(pipe_freeze), 32'(o[1]));
        chk("m_err_o", 32'(err_o), 32'(o[0]));
`ifdef HAZ_PERF_CNT_EN
        chk("m_stall_cnt", stall_cnt, 32'(m_stall));
        chk("m_flush_cnt", flush_cnt, 32'(m_flush));
        chk("m_miss_cnt", miss_cnt, 32'(m_miss));
`else
        chk("m_stall_cnt", stall_cnt, 32'd0);
        chk("m_flush_cnt", flush_cnt, 32'd0);
        chk("m_miss_cnt", miss_cnt, 32'd0);
`endif
    end

    task automatic step(input logic st, input logic mr, input logic [4:0] rt,
                        input logic [4:0] rs, input logic [4:0] irt, input logic br,
                        input logic rq, input logic ak);
        @(posedge clk);
        #1;
        start_i = st;
        memread = mr;
        ex_rt   = rt;
        id_rs   = rs;
        id_rt   = irt;
        branch  = br;
        mem_req = rq;
        mem_ack = ak;
        @(negedge clk);
    endtask

    task automatic idle_vals(input string tag);
        chk({tag, "_pc"}, 32'(PC_write), 32'd0);
        chk({tag, "_ifid"}, 32'(IFID_write), 32'd0);
        chk({tag, "_bubble"}, 32'(IDEX_bubble), 32'd1);
        chk({tag, "_freeze"}, 32'(pipe_freeze), 32'd0);
        chk({tag, "_err"}, 32'(err_o), 32'd0);
    endtask

    initial begin
        rst_i = 1'b0;
        start_i = 0; memread = 0; ex_rt = 0; id_rs = 0; id_rt = 0;
        branch = 0; mem_req = 0; mem_ack = 0;
        #3;
        idle_vals("reset");
        @(posedge clk);
        #1 rst_i = 1'b1;

        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0);
            idle_vals("hold");
        end
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle_vals("start_cycle");
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("run_pc", 32'(PC_write), 32'd1);
        chk("run_bubble", 32'(IDEX_bubble), 32'd0);

        step(0, 1, 8, 3, 8, 0, 0, 0);
        chk("lu_pc", 32'(PC_write), 32'd0);
        chk("lu_ifid", 32'(IFID_write), 32'd0);
        chk("lu_bubble", 32'(IDEX_bubble), 32'd1);
        step(0, 0, 8, 3, 8, 0, 0, 0);
        chk("lu_after_pc", 32'(PC_write), 32'd1);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        chk("rt0_pc", 32'(PC_write), 32'd1);
        chk("rt0_bubble", 32'(IDEX_bubble), 32'd0);

        step(0, 1, 5, 5, 9, 1, 0, 0);
        chk("lubr_flush", 32'(IFID_flush), 32'd0);
        chk("lubr_bubble", 32'(IDEX_bubble), 32'd1);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        chk("br_flush", 32'(IFID_flush), 32'd1);
        chk("br_pc", 32'(PC_write), 32'd1);

        step(0, 0, 0, 0, 0, 0, 1, 1);
        chk("zero_wait_freeze", 32'(pipe_freeze), 32'd0);
        chk("zero_wait_pc", 32'(PC_write), 32'd1);

        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0, 1, 0);
            chk("miss_freeze", 32'(pipe_freeze), 32'd1);
            chk("miss_pc", 32'(PC_write), 32'd0);
        end
        step(0, 1, 7, 7, 0, 1, 1, 1);
        chk("ack_freeze", 32'(pipe_freeze), 32'd0);
        chk("ack_pc", 32'(PC_write), 32'd1);
        chk("ack_bubble", 32'(IDEX_bubble), 32'd0);
        chk("ack_flush", 32'(IFID_flush), 32'd0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef HAZ_PERF_CNT_EN
        chk("lit_miss_cnt", miss_cnt, 32'd3);
        chk("lit_stall_cnt", stall_cnt, 32'd2);
        chk("lit_flush_cnt", flush_cnt, 32'd1);
`endif

        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 0, 1, 0);
            chk("to_freeze", 32'(pipe_freeze), 32'd1);
            chk("to_err", 32'(err_o), 32'd0);
        end
        step(0, 0, 0, 0, 0, 0, 1, 0);
        chk("halt_err", 32'(err_o), 32'd1);
        chk("halt_freeze", 32'(pipe_freeze), 32'd1);
        step(1, 0, 0, 0, 0, 1, 1, 1);
        chk("halt_sticky_err", 32'(err_o), 32'd1);
        chk("halt_sticky_pc", 32'(PC_write), 32'd0);
        chk("halt_sticky_flush", 32'(IFID_flush), 32'd0);
`ifdef HAZ_PERF_CNT_EN
        chk("lit_halt_miss_cnt", miss_cnt, 32'd7);
`endif

        #2 rst_i = 1'b0;
        #1;
        idle_vals("halt_rst");
        @(posedge clk);
        #1 rst_i = 1'b1;
`ifdef HAZ_PERF_CNT_EN
        chk("rst_miss_cnt", miss_cnt, 32'd0);
`endif

        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("restart_pc", 32'(PC_write), 32'd1);
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 0, 0, 0, 1, 0);
            chk("miss2_freeze", 32'(pipe_freeze), 32'd1);
        end
        #2 rst_i = 1'b0;
        #1;
        idle_vals("miss_rst");
        @(posedge clk);
        #1 rst_i = 1'b1;
        step(0, 0, 0, 0, 0, 0, 1, 1);
        idle_vals("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
